nibble_serial_addsub_ctrl: RTL and testbench

//   Sequences one 4-bit two's-complement add/subtract slice over WIDTH-bit operands.

---
 rtl/nibble_serial_addsub_ctrl_if.sv | 27 ++
 rtl/nibble_serial_addsub_ctrl.sv | 138 +++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/response bundle between a start/done requester and the
// nibble-serial add/subtract controller.
//   start, mode, a, b                  : requester -> controller
//   busy, done, result, carry, overflow: controller -> requester
interface nibble_serial_addsub_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, carry, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, carry, overflow
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial two's-complement add/subtract over WIDTH-bit operands,
// sharing one 4-bit slice. LSB nibble first, carry chained across cycles.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : async active-low reset, release synchronised to clk
//   io_bus : slave side of nibble_serial_addsub_ctrl_if
//            (start/mode/a/b in; busy/done/result/carry/overflow out)

// One 4-bit add/sub slice; also exposes the carry into bit 3 so the
// controller can form signed overflow on the top nibble.
module nibble_serial_addsub_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_inv,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_c3
);
  logic [3:0] w_bx;
  logic [3:0] w_lo;
  logic [1:0] w_hi;

  assign w_bx   = i_b ^ {4{i_inv}};
  assign w_lo   = {1'b0, i_a[2:0]} + {1'b0, w_bx[2:0]} + {3'b000, i_cin};
  assign o_c3   = w_lo[3];
  assign w_hi   = {1'b0, i_a[3]} + {1'b0, w_bx[3]} + {1'b0, o_c3};
  assign o_sum  = {w_hi[0], w_lo[2:0]};
  assign o_cout = w_hi[1];
endmodule

module nibble_serial_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_addsub_ctrl_if.slave  io_bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic             w_accept;
  logic             w_last;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic             r_mode, r_cy, r_carry, r_ovf;
  logic             r_rst_meta, r_rst_sync_n;
  logic [3:0]       w_sum;
  logic             w_cout, w_c3;

  // Assert asynchronously, release two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta   <= 1'b0;
      r_rst_sync_n <= 1'b0;
    end else begin
      r_rst_meta   <= 1'b1;
      r_rst_sync_n <= r_rst_meta;
    end
  end

  assign w_last = (r_idx == IW'(N - 1));

  nibble_serial_addsub_slice u_slice (
    .i_a    (r_a[{r_idx, 2'b00} +: 4]),
    .i_b    (r_b[{r_idx, 2'b00} +: 4]),
    .i_inv  (r_mode),
    .i_cin  (r_cy),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c3   (w_c3)
  );

  always_ff @(posedge clk or negedge r_rst_sync_n) begin
    if (!r_rst_sync_n) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  // DONE accepts a start just like IDLE, giving back-to-back operation.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (io_bus.start) begin
        w_next   = S_RUN;
        w_accept = 1'b1;
      end
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: begin
        if (io_bus.start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end else begin
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r_rst_sync_n) begin
    if (!r_rst_sync_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_cy     <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a    <= io_bus.a;
      r_b    <= io_bus.b;
      r_mode <= io_bus.mode;
      r_cy   <= io_bus.mode;  // subtract = A + ~B + 1
      r_idx  <= '0;
    end else if (r_state == S_RUN) begin
      r_result[{r_idx, 2'b00} +: 4] <= w_sum;
      r_cy <= w_cout;
      if (w_last) begin
        r_idx   <= '0;  // keeps the slice select in range while idle
        r_carry <= w_cout;
        r_ovf   <= w_cout ^ w_c3;
      end else begin
        r_idx   <= r_idx + IW'(1);
      end
    end
  end

  assign io_bus.busy     = (r_state == S_RUN);
  assign io_bus.done     = (r_state == S_DONE);
  assign io_bus.result   = r_result;
  assign io_bus.carry    = r_carry;
  assign io_bus.overflow = r_ovf;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
module tb_nibble_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_addsub_ctrl_if #(.WIDTH(4))  bus4 ();

  nibble_serial_addsub_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .io_bus(bus16));
  nibble_serial_addsub_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .io_bus(bus4));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [15:0] r;
    logic        c;
    logic        o;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int w, input int ua, input int ub, input bit m,
                       output int r, output bit c, output bit o);
    int lim, sa, sb, ex;
    lim = 1 << w;
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    if (m) begin
      r  = (ua - ub + lim) % lim;
      c  = (ua >= ub);
      ex = sa - sb;
    end else begin
      r  = (ua + ub) % lim;
      c  = (ua + ub) >= lim;
      ex = sa + sb;
    end
    o = (ex > lim / 2 - 1) || (ex < -(lim / 2));
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic m,
                      output int r, output bit c, output bit o, output int lat);
    bus16.a = a; bus16.b = b; bus16.mode = m; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.mode = 1'($urandom);
    lat = 1;
    while (!bus16.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = int'(bus16.result); c = bus16.carry; o = bus16.overflow;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic m,
                     output int r, output bit c, output bit o, output int lat);
    bus4.a = a; bus4.b = b; bus4.mode = m; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 1;
    while (!bus4.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = int'(bus4.result); c = bus4.carry; o = bus4.overflow;
  endtask

  vec_t vecs[7];

  initial begin
    int r, lat, er;
    bit c, o, ec, eo;
    logic [15:0] ra, rb;
    logic rm;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a = '0; bus16.b = '0;
    bus4.start  = 1'b0; bus4.mode  = 1'b0; bus4.a  = '0; bus4.b  = '0;
    #23;
    chk("rst_busy",   bus16.busy,     0);
    chk("rst_done",   bus16.done,     0);
    chk("rst_result", bus16.result,   0);
    chk("rst_carry",  bus16.carry,    0);
    chk("rst_ovf",    bus16.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed vectors.
    foreach (vecs[i]) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].m, r, c, o, lat);
      chk($sformatf("vec%0d_lat", i),    lat, 5);
      chk($sformatf("vec%0d_result", i), r,   int'(vecs[i].r));
      chk($sformatf("vec%0d_carry", i),  c,   vecs[i].c);
      chk($sformatf("vec%0d_ovf", i),    o,   vecs[i].o);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), bus16.done, 0);
    end

    // start held high with changing operands while busy, then accepted in DONE.
    bus16.a = 16'h1234; bus16.b = 16'h0FCD; bus16.mode = 1'b0; bus16.start = 1'b1;
    @(negedge clk);
    chk("hold_busy", bus16.busy, 1);
    bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.mode = 1'b1;
    lat = 1;
    while (!bus16.done && lat < 20) begin @(negedge clk); lat++; end
    chk("hold_lat",    lat,           5);
    chk("hold_result", bus16.result,  16'h2201);
    chk("hold_carry",  bus16.carry,   0);
    @(negedge clk);
    chk("b2b_busy", bus16.busy, 1);
    bus16.start = 1'b0;
    lat = 1;
    while (!bus16.done && lat < 20) begin @(negedge clk); lat++; end
    model(16, 16'hAAAA, 16'h5555, 1'b1, er, ec, eo);
    chk("b2b_lat",    lat,            5);
    chk("b2b_result", bus16.result,   er);
    chk("b2b_carry",  bus16.carry,    ec);
    chk("b2b_ovf",    bus16.overflow, eo);
    @(negedge clk);

    // Reset during the second RUN cycle, after an op that left carry/ovf set.
    op16(16'h8000, 16'h8000, 1'b0, r, c, o, lat);
    @(negedge clk);
    bus16.a = 16'h1111; bus16.b = 16'h1111; bus16.mode = 1'b0; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   bus16.busy,     0);
    chk("mid_rst_done",   bus16.done,     0);
    chk("mid_rst_result", bus16.result,   0);
    chk("mid_rst_carry",  bus16.carry,    0);
    chk("mid_rst_ovf",    bus16.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", bus16.busy, 0);
    op16(16'h0123, 16'h0456, 1'b1, r, c, o, lat);
    model(16, 16'h0123, 16'h0456, 1'b1, er, ec, eo);
    chk("post_rst_lat",    lat, 5);
    chk("post_rst_result", r,   er);
    chk("post_rst_carry",  c,   ec);
    chk("post_rst_ovf",    o,   eo);
    @(negedge clk);

    // Randomized ops, mixing back-to-back and idle gaps.
    for (int k = 0; k < 60; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
      if (k % 5 == 0) ra = 16'h8000 | 16'($urandom_range(0, 3));
      op16(ra, rb, rm, r, c, o, lat);
      model(16, int'(ra), int'(rb), rm, er, ec, eo);
      chk("rnd_lat",    lat, 5);
      chk("rnd_result", r,   er);
      chk("rnd_carry",  c,   ec);
      chk("rnd_ovf",    o,   eo);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // WIDTH=4: exhaustive against direct 4-bit arithmetic, back-to-back.
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          op4(4'(x), 4'(y), 1'(m), r, c, o, lat);
          model(4, x, y, 1'(m), er, ec, eo);
          chk("w4_lat",    lat, 2);
          chk("w4_result", r,   er);
          chk("w4_carry",  c,   ec);
          chk("w4_ovf",    o,   eo);
        end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
